// File: rtl/alu_pkg.sv
// Shared ALU opcode, flag and arbiter FSM definitions.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SRL  = 4'd2,
        SLL  = 4'd3,
        OR   = 4'd4,
        NOR  = 4'd5,
        AND  = 4'd6,
        NAND = 4'd7,
        XOR  = 4'd8,
        NOT  = 4'd9
    } alu_op_t;

    localparam int FLAG_Z     = 0;
    localparam int FLAG_N     = 1;
    localparam int FLAG_C     = 2;
    localparam int ALU_OP_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Internally computes a (DATA_WIDTH+1)-bit result so the
// carry/borrow out of ADD/SUB and the last bit shifted out of SLL land in C.
// Undefined opcodes produce result 0 (hence Z=1).
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] flags
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH:0] res;
    logic [SH_W-1:0]     sh;

    assign sh = b[SH_W-1:0];

    // Operation decode into the extended result
    always_comb begin
        res = '0;
        case (op)
            DATA_WIDTH'(ADD):  res = {1'b0, a} + {1'b0, b};
            DATA_WIDTH'(SUB):  res = {1'b0, a} - {1'b0, b};
            DATA_WIDTH'(SRL):  res = {1'b0, a >> sh};
            DATA_WIDTH'(SLL):  res = {1'b0, a} << sh;
            DATA_WIDTH'(OR):   res = {1'b0, a | b};
            DATA_WIDTH'(NOR):  res = {1'b0, ~(a | b)};
            DATA_WIDTH'(AND):  res = {1'b0, a & b};
            DATA_WIDTH'(NAND): res = {1'b0, ~(a & b)};
            DATA_WIDTH'(XOR):  res = {1'b0, a ^ b};
            DATA_WIDTH'(NOT):  res = {1'b0, ~a};
            default:           res = '0;
        endcase
    end

    // Result and {C,N,Z} flags from the extended result
    always_comb begin
        dout          = res[DATA_WIDTH-1:0];
        flags         = '0;
        flags[FLAG_Z] = (res[DATA_WIDTH-1:0] == '0);
        flags[FLAG_N] = res[DATA_WIDTH-1];
        flags[FLAG_C] = res[DATA_WIDTH];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin grant: first asserted request at or
// above ptr, wrapping around. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Scan farthest-from-pointer first so the nearest requester wins last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, one
// cycle of execution from registered operands, then a held response
// tagged with the requester index.
//
// state | meaning
// IDLE  | no operation in flight, arbitrating requesters
// EXEC  | operands registered and driving the ALU
// RESP  | result held on the response channel until accepted
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_dout,
    output logic [DATA_WIDTH-1:0]         rsp_flags,
    output logic                          rsp_err
);

    arb_state_t            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id_q;
    logic [DATA_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] alu_dout;
    logic [DATA_WIDTH-1:0] alu_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready only while arbitrating; gated by rst_n so nothing is accepted in reset
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;

    // Payload mux for the granted requester
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i*DATA_WIDTH +: DATA_WIDTH];
                sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .dout  (alu_dout),
        .flags (alu_flags)
    );

    // Sequencing FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dout  <= '0;
            rsp_flags <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_dout  <= alu_dout;
                    rsp_flags <= alu_flags;
                    rsp_err   <= (op_q > DATA_WIDTH'(ALU_OP_MAX));
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a driver feeds per-requester vector
// queues and pushes expected responses on accept; a monitor pops and
// compares on every response handshake.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int NR = 2;
    localparam int IW = 1;

    typedef struct {
        logic [DW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] dout;
        logic [DW-1:0] flags;
        logic          err;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] dout;
        logic [DW-1:0] flags;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_op;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_dout;
    logic [DW-1:0]    rsp_flags;
    logic             rsp_err;

    vec_t vq[NR][$];
    exp_t sb[$];
    int   grant_log[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc_cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_rv = 1'b0;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] dout, input logic [DW-1:0] flags, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.dout = dout; v.flags = flags; v.err = err;
        return v;
    endfunction

    // Driver: present queue heads after each rising edge, detect accepts before the next one
    initial begin
        bit   took[NR];
        exp_t e;
        vec_t v;
        for (int r = 0; r < NR; r++) took[r] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (took[r] && vq[r].size() > 0) void'(vq[r].pop_front());
                took[r] = 1'b0;
                if (vq[r].size() > 0) begin
                    v = vq[r][0];
                    req_valid[r]         = 1'b1;
                    req_op[r*DW +: DW]   = v.op;
                    req_a[r*DW +: DW]    = v.a;
                    req_b[r*DW +: DW]    = v.b;
                end else begin
                    req_valid[r]         = 1'b0;
                    req_op[r*DW +: DW]   = 16'hDEAD;
                    req_a[r*DW +: DW]    = 16'hBEEF;
                    req_b[r*DW +: DW]    = 16'h5A5A;
                end
            end
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    took[r] = 1'b1;
                    v = vq[r][0];
                    e.id = r; e.dout = v.dout; e.flags = v.flags; e.err = v.err;
                    sb.push_back(e);
                    grant_log.push_back(r);
                    acc_cyc.push_back(cyc);
                    last_acc_cyc = cyc;
                    acc_cnt++;
                end
            end
        end
    end

    // Monitor: one-hot ready, response latency, scoreboard compare on handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!$onehot0(req_ready)) begin
                checks++;
                failures++;
                $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
            end
            if (rst_n) begin
                if (rsp_valid && !prev_rv) chk("rsp_latency", cyc - last_acc_cyc, 2);
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 32'(rsp_id), e.id);
                        chk("rsp_dout", rsp_dout, e.dout);
                        chk("rsp_flags", rsp_flags, e.flags);
                        chk("rsp_err", rsp_err, e.err);
                    end
                end
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic reset_checks();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dout", rsp_dout, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(vq[0].size() == 0 && vq[1].size() == 0 && sb.size() == 0 &&
                 !rsp_valid && req_valid == '0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk({name, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        int k;
        int exp_order[4] = '{0, 1, 0, 1};

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        // Contention: both requesters valid from reset
        vq[0].push_back(mk(16'd1, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0));
        vq[0].push_back(mk(16'd1, 16'h0010, 16'h0010, 16'h0000, 16'h0001, 1'b0));
        vq[1].push_back(mk(16'd8, 16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0002, 1'b0));
        vq[1].push_back(mk(16'd8, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0002, 1'b0));

        repeat (3) begin
            @(negedge clk);
            reset_checks();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("contention");
        chk("contention_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("contention_order", grant_log[i], exp_order[i]);

        // Single ADD with carry-out and zero result
        vq[0].push_back(mk(16'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0005, 1'b0));
        wait_idle("single_add");

        // Illegal opcode
        vq[1].push_back(mk(16'h000C, 16'h1234, 16'h0000, 16'h0000, 16'h0001, 1'b1));
        wait_idle("illegal_op");

        // Throughput batch covering the remaining opcodes
        acc_cyc.delete();
        vq[0].push_back(mk(16'd3, 16'h8001, 16'h0001, 16'h0002, 16'h0004, 1'b0));
        vq[0].push_back(mk(16'd2, 16'h8000, 16'h0004, 16'h0800, 16'h0000, 1'b0));
        vq[0].push_back(mk(16'd5, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 1'b0));
        vq[0].push_back(mk(16'd6, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0001, 1'b0));
        vq[0].push_back(mk(16'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0));
        vq[0].push_back(mk(16'd4, 16'h1200, 16'h0034, 16'h1234, 16'h0000, 1'b0));
        vq[0].push_back(mk(16'd9, 16'h00FF, 16'h0000, 16'hFF00, 16'h0002, 1'b0));
        vq[0].push_back(mk(16'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0006, 1'b0));
        wait_idle("throughput");
        chk("tp_accepts", acc_cyc.size(), 8);
        for (int i = 1; i < acc_cyc.size(); i++) chk("tp_interval", acc_cyc[i] - acc_cyc[i-1], 3);

        // Backpressure: requester 1 first (pointer is 1), requester 0 waits
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        vq[1].push_back(mk(16'd0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0002, 1'b0));
        vq[0].push_back(mk(16'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0));
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("bp_rsp_timeout", 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_dout", rsp_dout, 16'h8000);
            chk("bp_flags", rsp_flags, 16'h0002);
            chk("bp_id", 32'(rsp_id), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", rsp_valid, 0);
        wait_idle("backpressure");

        // Reset in EXEC: op discarded, pointer cleared
        vq[0].push_back(mk(16'd0, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 1'b0));
        n0 = acc_cnt;
        k = 0;
        while (acc_cnt == n0 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 20) chk("mid_rst_accept_timeout", 1, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        grant_log.delete();
        vq[0].push_back(mk(16'd4, 16'h1200, 16'h0034, 16'h1234, 16'h0000, 1'b0));
        vq[1].push_back(mk(16'd6, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0001, 1'b0));
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            reset_checks();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("after_reset");
        chk("post_rst_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("post_rst_first_grant", grant_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
